// File: rtl/rob_pkg.sv
// Shared types for the rename file and reorder buffer.
// Operand bundle, tag type, opcode encoding, popcount helper.
package rob_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_W     = 3;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic            is_tag;
    tag_t            tag;
    logic [XLEN-1:0] data;
  } operand_t;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_MUL    = 2'b01,
    OP_BRANCH = 2'b10
  } opcode_e;

  function automatic logic [5:0] popcount(
    input logic [NUM_REGS-1:0] v
  );
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt = cnt + 6'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/operand_read_port.sv
// One source-operand lookup: zero reg, commit bypass,
// pending tag, or committed value.
module operand_read_port
  import rob_pkg::*;
(
  input  logic [REG_IDX_W-1:0]           rs,
  input  logic [NUM_REGS-1:0]            busy,
  input  tag_t [NUM_REGS-1:0]            tags,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
  input  logic                           commit_valid,
  input  logic [REG_IDX_W-1:0]           commit_rd,
  input  tag_t                           commit_tag,
  input  logic [XLEN-1:0]                commit_data,
  output operand_t                       op
);

  logic hit;

  assign hit = busy[rs] && commit_valid
            && (commit_rd == rs)
            && (commit_tag == tags[rs]);

  // Conditions overlap, so this is an ordered priority chain.
  always_comb begin
    op = '0;
    if (rs == '0) begin
      op = '0;
    end else if (hit) begin
      op.data = commit_data;
    end else if (busy[rs]) begin
      op.is_tag = 1'b1;
      op.tag    = tags[rs];
    end else begin
      op.data = regs[rs];
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus register status table.
// Renames at dispatch, retires on ROB commit, clears on flush.
module reg_rename_file
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_valid,
  input  logic                 disp_writes_rd,
  input  logic [4:0]           disp_rs1,
  input  logic [4:0]           disp_rs2,
  input  logic [4:0]           disp_rd,
  input  logic [TAG_W-1:0]     disp_tag,
  output logic [XLEN-1:0]      rs1_data,
  output logic [XLEN-1:0]      rs2_data,
  output logic                 rs1_is_tag,
  output logic                 rs2_is_tag,
  output logic [TAG_W-1:0]     rs1_tag,
  output logic [TAG_W-1:0]     rs2_tag,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic [XLEN-1:0]      commit_data,
  input  logic                 flush,
  output logic [5:0]           busy_count
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [NUM_REGS-1:0]           busy, busy_nxt;
  tag_t [NUM_REGS-1:0]           tags, tags_nxt;
  operand_t                      op1, op2;
  logic                          rename, commit_we;

  assign rename    = disp_valid && disp_writes_rd
                  && (disp_rd != '0) && !flush;
  assign commit_we = commit_valid && (commit_rd != '0);

  // Rename applied after the commit clear so it wins on a race.
  always_comb begin
    busy_nxt = busy;
    tags_nxt = tags;
    if (commit_we && (tags[commit_rd] == commit_tag))
      busy_nxt[commit_rd] = 1'b0;
    if (flush) begin
      busy_nxt = '0;
      tags_nxt = '0;
    end else if (rename) begin
      busy_nxt[disp_rd] = 1'b1;
      tags_nxt[disp_rd] = disp_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs       <= '0;
      busy       <= '0;
      tags       <= '0;
      busy_count <= '0;
    end else begin
      if (commit_we)
        regs[commit_rd] <= commit_data;
      busy       <= busy_nxt;
      tags       <= tags_nxt;
      busy_count <= popcount(busy_nxt);
    end
  end

  operand_read_port u_rs1 (
    .rs           (disp_rs1),
    .busy         (busy),
    .tags         (tags),
    .regs         (regs),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_data  (commit_data),
    .op           (op1)
  );

  operand_read_port u_rs2 (
    .rs           (disp_rs2),
    .busy         (busy),
    .tags         (tags),
    .regs         (regs),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_data  (commit_data),
    .op           (op2)
  );

  assign rs1_data   = op1.data;
  assign rs1_is_tag = op1.is_tag;
  assign rs1_tag    = op1.tag;
  assign rs2_data   = op2.data;
  assign rs2_is_tag = op2.is_tag;
  assign rs2_tag    = op2.tag;

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: reset, rename/commit,
// WAW, self-dependency race, flush and x0 handling.
module tb_reg_rename_file;
  import rob_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             disp_valid, disp_writes_rd;
  logic [4:0]       disp_rs1, disp_rs2, disp_rd;
  logic [TAG_W-1:0] disp_tag;
  logic [XLEN-1:0]  rs1_data, rs2_data;
  logic             rs1_is_tag, rs2_is_tag;
  logic [TAG_W-1:0] rs1_tag, rs2_tag;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_data;
  logic             flush;
  logic [5:0]       busy_count;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_valid     (disp_valid),
    .disp_writes_rd (disp_writes_rd),
    .disp_rs1       (disp_rs1),
    .disp_rs2       (disp_rs2),
    .disp_rd        (disp_rd),
    .disp_tag       (disp_tag),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rs1_is_tag     (rs1_is_tag),
    .rs2_is_tag     (rs2_is_tag),
    .rs1_tag        (rs1_tag),
    .rs2_tag        (rs2_tag),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_tag     (commit_tag),
    .commit_data    (commit_data),
    .flush          (flush),
    .busy_count     (busy_count)
  );

  task automatic idle();
    disp_valid     = 1'b0;
    disp_writes_rd = 1'b0;
    disp_rd        = '0;
    disp_tag       = '0;
    commit_valid   = 1'b0;
    commit_rd      = '0;
    commit_tag     = '0;
    commit_data    = '0;
    flush          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [2:0] t);
    disp_valid     = 1'b1;
    disp_writes_rd = 1'b1;
    disp_rd        = rd;
    disp_tag       = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [2:0] t,
                        input logic [31:0] d);
    commit_valid = 1'b1;
    commit_rd    = rd;
    commit_tag   = t;
    commit_data  = d;
  endtask

  task automatic test_reset();
    idle();
    disp_rs1 = 5'd5;
    disp_rs2 = 5'd0;
    rst_n    = 1'b0;
    rename(5'd9, 3'd1);
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_run++;
    if (rs1_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", rs1_data);
    end
    n_run++;
    if (rs1_is_tag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_is_tag got %b want 0", rs1_is_tag);
    end
    n_run++;
    if (busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_busy_count got %0d want 0", busy_count);
    end
  endtask

  task automatic test_rename_commit();
    rename(5'd3, 3'd2);
    tick();
    idle();
    disp_rs1 = 5'd3;
    disp_rs2 = 5'd3;
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag, rs1_data} !== {1'b1, 3'd2, 32'h0}) begin
      n_fail++;
      $display("FAIL rc_rs1_pending got %b/%0d/%h want 1/2/0",
               rs1_is_tag, rs1_tag, rs1_data);
    end
    n_run++;
    if ({rs2_is_tag, rs2_tag} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL rc_rs2_pending got %b/%0d want 1/2",
               rs2_is_tag, rs2_tag);
    end
    n_run++;
    if (busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL rc_busy1 got %0d want 1", busy_count);
    end
    commit(5'd3, 3'd2, 32'h1234);
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag, rs1_data} !== {1'b0, 3'd0, 32'h1234}) begin
      n_fail++;
      $display("FAIL rc_bypass got %b/%0d/%h want 0/0/1234",
               rs1_is_tag, rs1_tag, rs1_data);
    end
    tick();
    idle();
    #1;
    n_run++;
    if (busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL rc_busy0 got %0d want 0", busy_count);
    end
    n_run++;
    if ({rs2_is_tag, rs2_data} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL rc_committed got %b/%h want 0/1234",
               rs2_is_tag, rs2_data);
    end
  endtask

  task automatic test_waw();
    rename(5'd4, 3'd1);
    tick();
    rename(5'd4, 3'd5);
    tick();
    idle();
    disp_rs1 = 5'd4;
    disp_rs2 = 5'd0;
    commit(5'd4, 3'd1, 32'd7);
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag} !== {1'b1, 3'd5}) begin
      n_fail++;
      $display("FAIL waw_no_stale_bypass got %b/%0d want 1/5",
               rs1_is_tag, rs1_tag);
    end
    tick();
    idle();
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag, rs1_data} !== {1'b1, 3'd5, 32'h0}) begin
      n_fail++;
      $display("FAIL waw_still_pending got %b/%0d/%h want 1/5/0",
               rs1_is_tag, rs1_tag, rs1_data);
    end
    n_run++;
    if (busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL waw_busy1 got %0d want 1", busy_count);
    end
    commit(5'd4, 3'd5, 32'd9);
    tick();
    idle();
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_data} !== {1'b0, 32'd9}) begin
      n_fail++;
      $display("FAIL waw_final got %b/%h want 0/9", rs1_is_tag, rs1_data);
    end
    n_run++;
    if (busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL waw_busy0 got %0d want 0", busy_count);
    end
  endtask

  task automatic test_self_dep();
    rename(5'd6, 3'd3);
    tick();
    rename(5'd6, 3'd4);
    disp_rs1 = 5'd6;
    disp_rs2 = 5'd6;
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL self_old_mapping got %b/%0d want 1/3",
               rs1_is_tag, rs1_tag);
    end
    commit(5'd6, 3'd3, 32'h66);
    #1;
    n_run++;
    if ({rs2_is_tag, rs2_data} !== {1'b0, 32'h66}) begin
      n_fail++;
      $display("FAIL self_race_bypass got %b/%h want 0/66",
               rs2_is_tag, rs2_data);
    end
    tick();
    idle();
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag} !== {1'b1, 3'd4}) begin
      n_fail++;
      $display("FAIL self_rename_wins got %b/%0d want 1/4",
               rs1_is_tag, rs1_tag);
    end
    n_run++;
    if (busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL self_busy1 got %0d want 1", busy_count);
    end
    commit(5'd6, 3'd4, 32'h77);
    tick();
    idle();
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_data, busy_count} !== {1'b0, 32'h77, 6'd0}) begin
      n_fail++;
      $display("FAIL self_final got %b/%h/%0d want 0/77/0",
               rs1_is_tag, rs1_data, busy_count);
    end
  endtask

  task automatic test_flush();
    rename(5'd1, 3'd0);
    tick();
    rename(5'd2, 3'd1);
    tick();
    rename(5'd7, 3'd2);
    tick();
    idle();
    #1;
    n_run++;
    if (busy_count !== 6'd3) begin
      n_fail++;
      $display("FAIL flush_busy3 got %0d want 3", busy_count);
    end
    rename(5'd8, 3'd3);
    commit(5'd7, 3'd7, 32'hAB);
    flush = 1'b1;
    tick();
    idle();
    disp_rs1 = 5'd8;
    disp_rs2 = 5'd3;
    #1;
    n_run++;
    if (busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_busy0 got %0d want 0", busy_count);
    end
    n_run++;
    if ({rs1_is_tag, rs1_tag, rs1_data} !== {1'b0, 3'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_x8 got %b/%0d/%h want 0/0/0",
               rs1_is_tag, rs1_tag, rs1_data);
    end
    n_run++;
    if ({rs2_is_tag, rs2_data} !== {1'b0, 32'h1234}) begin
      n_fail++;
      $display("FAIL flush_x3_kept got %b/%h want 0/1234",
               rs2_is_tag, rs2_data);
    end
    disp_rs1 = 5'd7;
    disp_rs2 = 5'd2;
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_data} !== {1'b0, 32'hAB}) begin
      n_fail++;
      $display("FAIL flush_commit_write got %b/%h want 0/ab",
               rs1_is_tag, rs1_data);
    end
    n_run++;
    if ({rs2_is_tag, rs2_data} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_x2_clear got %b/%h want 0/0",
               rs2_is_tag, rs2_data);
    end
  endtask

  task automatic test_x0();
    rename(5'd5, 3'd6);
    tick();
    rename(5'd0, 3'd2);
    commit(5'd0, 3'd0, 32'hFFFF);
    disp_rs1 = 5'd0;
    disp_rs2 = 5'd5;
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_data} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_no_bypass got %b/%h want 0/0",
               rs1_is_tag, rs1_data);
    end
    tick();
    idle();
    #1;
    n_run++;
    if ({rs1_is_tag, rs1_tag, rs1_data} !== {1'b0, 3'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_read got %b/%0d/%h want 0/0/0",
               rs1_is_tag, rs1_tag, rs1_data);
    end
    n_run++;
    if (busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL x0_busy_count got %0d want 1", busy_count);
    end
    n_run++;
    if ({rs2_is_tag, rs2_tag} !== {1'b1, 3'd6}) begin
      n_fail++;
      $display("FAIL x0_x5_pending got %b/%0d want 1/6",
               rs2_is_tag, rs2_tag);
    end
  endtask

  initial begin
    idle();
    rst_n    = 1'b1;
    disp_rs1 = '0;
    disp_rs2 = '0;
    @(negedge clk);
    test_reset();
    test_rename_commit();
    test_waw();
    test_self_dep();
    test_flush();
    test_x0();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
